stream_packetizer: RTL and testbench

Single-clock framing stage directly downstream of `async_fifo`, on its read side. It pops 32-bit samples from the FIFO and emits them on a valid/ready stream as fixed-length packets. Each packet is one header word (sync pattern plus 16-bit sequence number) followed by `PKT_LEN` payload words, with `m_last` on the final word. Its output feeds the host link (USB/Ethernet streamer).

---
 rtl/sdr_stream_pkg.sv | 17 +
 rtl/pkt_skid_buf.sv | 57 +++++
 rtl/stream_packetizer.sv | 128 ++++++++++++
 tb/tb_stream_packetizer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_stream_pkg.sv
// Shared types and helpers for the SDR sample streaming path.
package sdr_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } pkt_state_e;

    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hA55A;
    localparam int          BUF_DEPTH         = 4;

    function automatic logic [31:0] build_header(input logic [15:0] sync, input logic [15:0] seq);
        return {sync, seq};
    endfunction

endpackage

// File: rtl/pkt_skid_buf.sv
// Depth-4 synchronous FIFO holding fetched payload words until the stream accepts them.
module pkt_skid_buf
    import sdr_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [2:0]       occupancy
);

    logic [WIDTH-1:0] mem_r [0:BUF_DEPTH-1];
    logic [1:0]       wr_ptr_r;
    logic [1:0]       rd_ptr_r;
    logic [2:0]       count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests so the pointers never run past the stored data.
    always_comb begin
        do_pop_s  = pop && (count_r != 3'd0);
        do_push_s = push && ((count_r != 3'd4) || do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + 2'd1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head      = mem_r[rd_ptr_r];
    assign occupancy = count_r;

endmodule

// File: rtl/stream_packetizer.sv
// Pops samples from the read side of async_fifo and frames them as
// header + PKT_LEN payload words on a valid/ready stream.
module stream_packetizer
    import sdr_stream_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          PKT_LEN   = 256,
    parameter logic [15:0] SYNC_WORD = DEFAULT_SYNC_WORD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [15:0]      seq_num
);

    pkt_state_e       state_r;
    pkt_state_e       state_nxt_s;
    logic [15:0]      seq_r;
    logic [16:0]      fetched_r;
    logic [15:0]      sent_r;
    logic             inflight_r;
    logic [2:0]       occ_s;
    logic [WIDTH-1:0] head_s;
    logic             start_s;
    logic             payload_valid_s;
    logic             sent_last_s;
    logic             pop_s;
    logic             last_hs_s;
    logic             fetch_ok_s;

    pkt_skid_buf #(.WIDTH(WIDTH)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_r),
        .pop       (pop_s),
        .din       (fifo_dout),
        .head      (head_s),
        .occupancy (occ_s)
    );

    // Handshake and fetch qualifiers; fetching stops at PKT_LEN so no word crosses a packet boundary.
    always_comb begin
        start_s         = enable && !fifo_empty;
        payload_valid_s = (occ_s != 3'd0);
        sent_last_s     = (sent_r == 16'(PKT_LEN - 1));
        pop_s           = (state_r == ST_PAYLOAD) && payload_valid_s && m_ready;
        last_hs_s       = pop_s && sent_last_s;
        fetch_ok_s      = ((state_r == ST_HEADER) || (state_r == ST_PAYLOAD)) &&
                          (fetched_r < 17'(PKT_LEN));
        fifo_rd_en      = fetch_ok_s && !fifo_empty &&
                          (({1'b0, occ_s} + {3'b000, inflight_r}) <= 4'd2);
    end

    // Next-state and stream outputs.
    always_comb begin
        state_nxt_s = state_r;
        m_valid     = 1'b0;
        m_data      = '0;
        m_last      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_HEADER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HEADER: begin
                m_valid = 1'b1;
                m_data  = WIDTH'(build_header(SYNC_WORD, seq_r));
                if (m_ready) begin
                    state_nxt_s = ST_PAYLOAD;
                end else begin
                    state_nxt_s = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                m_valid = payload_valid_s;
                m_data  = head_s;
                m_last  = sent_last_s;
                if (last_hs_s) begin
                    state_nxt_s = start_s ? ST_HEADER : ST_IDLE;
                end else begin
                    state_nxt_s = ST_PAYLOAD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, sequence number and per-packet counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            seq_r      <= 16'd0;
            fetched_r  <= 17'd0;
            sent_r     <= 16'd0;
            inflight_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            inflight_r <= fifo_rd_en;
            if (last_hs_s) begin
                seq_r     <= seq_r + 16'd1;
                fetched_r <= 17'd0;
                sent_r    <= 16'd0;
            end else begin
                if (fifo_rd_en) begin
                    fetched_r <= fetched_r + 17'd1;
                end
                if (pop_s) begin
                    sent_r <= sent_r + 16'd1;
                end
            end
        end
    end

    assign seq_num = seq_r;

endmodule

// File: tb/tb_stream_packetizer.sv
// Directed, table-driven bench for stream_packetizer with WIDTH=32, PKT_LEN=4
// and a behavioural FIFO with one-cycle read latency.
module tb_stream_packetizer;

    localparam int W  = 32;
    localparam int PL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [W-1:0]  fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [15:0]   seq_num;

    always #5 clk = ~clk;

    stream_packetizer #(.WIDTH(W), .PKT_LEN(PL), .SYNC_WORD(16'hA55A)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .seq_num    (seq_num)
    );

    typedef struct { logic [31:0] data; logic last; } vec_t;
    typedef struct { logic [31:0] data; logic last; int cyc; } beat_t;

    logic [31:0] fq[$];
    logic [31:0] ld_q[$];
    logic        flush_req = 1'b0;
    beat_t       rx[$];
    vec_t        exp_tbl[10];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic [3:0]  rpat = 4'b1001;

    // FIFO model: pop (1-cycle latency), then flush, then apply queued writes.
    always @(posedge clk) begin
        if (fifo_rd_en && (fq.size() > 0)) begin
            fifo_dout <= fq.pop_front();
        end
        if (flush_req) begin
            fq.delete();
        end
        while (ld_q.size() > 0) begin
            fq.push_back(ld_q.pop_front());
        end
        fifo_empty <= (fq.size() == 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One cycle: sample #1 after the negedge drive, record handshakes, advance.
    task automatic cycle();
        #1;
        if (fifo_empty) chk("rd_en_while_empty", fifo_rd_en, 1'b0);
        chk("buf_occ_le4", u_dut.u_buf.occupancy <= 3'd4, 1'b1);
        if (prev_stall) begin
            chk("stall_valid", m_valid, 1'b1);
            chk("stall_data", m_data, prev_data);
            chk("stall_last", m_last, prev_last);
        end
        if (m_valid && m_ready) rx.push_back('{m_data, m_last, cyc});
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_beats(input int n, input int budget, input bit use_pat);
        int k;
        k = 0;
        while ((rx.size() < n) && (k < budget)) begin
            m_ready = use_pat ? rpat[cyc % 4] : 1'b1;
            cycle();
            k++;
        end
        chk("beats_within_budget", rx.size() >= n, 1'b1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load(input int first, input int count);
        for (int i = 0; i < count; i++) ld_q.push_back(32'(first + i));
    endtask

    task automatic enter_reset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        m_ready    = 1'b0;
        flush_req  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        flush_req  = 1'b0;
        rx.delete();
        prev_stall = 1'b0;
    endtask

    task automatic compare_stream(input string tag, input int first, input int n);
        chk({tag, "_count"}, rx.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < rx.size()) begin
                chk($sformatf("%s_data%0d", tag, i), rx[i].data, exp_tbl[first + i].data);
                chk($sformatf("%s_last%0d", tag, i), rx[i].last, exp_tbl[first + i].last);
            end else begin
                chk($sformatf("%s_present%0d", tag, i), 1'b0, 1'b1);
            end
        end
    endtask

    initial begin
        int c0;
        int rd_cnt;
        exp_tbl[0] = '{32'hA55A0000, 1'b0};
        exp_tbl[1] = '{32'd0, 1'b0};
        exp_tbl[2] = '{32'd1, 1'b0};
        exp_tbl[3] = '{32'd2, 1'b0};
        exp_tbl[4] = '{32'd3, 1'b1};
        exp_tbl[5] = '{32'hA55A0001, 1'b0};
        exp_tbl[6] = '{32'd4, 1'b0};
        exp_tbl[7] = '{32'd5, 1'b0};
        exp_tbl[8] = '{32'd6, 1'b0};
        exp_tbl[9] = '{32'd7, 1'b1};

        // Reset: outputs zero and no pops even with data in the FIFO.
        rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        load(0, 8);
        enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_valid", m_valid, 1'b0);
            chk("rst_data", m_data, 32'd0);
            chk("rst_last", m_last, 1'b0);
            chk("rst_seq", seq_num, 16'd0);
            chk("rst_rd_en", fifo_rd_en, 1'b0);
            @(negedge clk);
        end
        chk("rst_fifo_loaded", fifo_empty, 1'b0);

        // Two back-to-back packets with m_ready held high.
        rst_n = 1'b1;
        c0 = cyc;
        run_beats(10, 60, 1'b0);
        compare_stream("full", 0, 10);
        if (rx.size() >= 10) begin
            chk("hdr_latency", rx[0].cyc, c0 + 1);
            for (int i = 2; i <= 4; i++) chk($sformatf("gap_p0_%0d", i), rx[i].cyc, rx[i-1].cyc + 1);
            for (int i = 7; i <= 9; i++) chk($sformatf("gap_p1_%0d", i), rx[i].cyc, rx[i-1].cyc + 1);
        end
        chk("seq_after_two", seq_num, 16'd2);
        idle_cycles(4);
        chk("idle_valid_after_two", m_valid, 1'b0);

        // Same data with backpressure pattern 1,0,0,1.
        enter_reset();
        load(0, 8);
        @(negedge clk);
        rst_n = 1'b1; enable = 1'b1;
        run_beats(10, 120, 1'b1);
        compare_stream("stall", 0, 10);
        chk("seq_after_stall", seq_num, 16'd2);

        // Underflow mid-packet: only 0,1 available, then 2,3 arrive later.
        enter_reset();
        load(0, 2);
        @(negedge clk);
        rst_n = 1'b1; enable = 1'b1;
        run_beats(3, 30, 1'b0);
        idle_cycles(6);
        chk("underflow_valid", m_valid, 1'b0);
        chk("underflow_held", rx.size(), 3);
        load(2, 2);
        run_beats(5, 30, 1'b0);
        compare_stream("underflow", 0, 5);

        // enable dropped right after the header handshake.
        enter_reset();
        load(0, 8);
        @(negedge clk);
        rst_n = 1'b1; enable = 1'b1;
        run_beats(1, 20, 1'b0);
        enable = 1'b0;
        run_beats(5, 30, 1'b0);
        rd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (fifo_rd_en) rd_cnt++;
            cycle();
        end
        compare_stream("disable", 0, 5);
        chk("disable_no_pops", rd_cnt, 0);
        chk("disable_fifo_left", fq.size(), 4);
        if (fq.size() > 0) chk("disable_fifo_head", fq[0], 32'd4);
        chk("disable_valid", m_valid, 1'b0);
        chk("disable_seq", seq_num, 16'd1);

        // Reset mid-packet after payload word 1, then restart from seq 0.
        enter_reset();
        load(0, 8);
        @(negedge clk);
        rst_n = 1'b1; enable = 1'b1;
        run_beats(3, 30, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", m_valid, 1'b0);
        chk("midrst_seq", seq_num, 16'd0);
        chk("midrst_rd_en", fifo_rd_en, 1'b0);
        @(negedge clk);
        enter_reset();
        load(0, 4);
        @(negedge clk);
        rst_n = 1'b1; enable = 1'b1;
        run_beats(5, 30, 1'b0);
        compare_stream("midrst", 0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
